// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling off a per-bit counter,
// one-cycle valid / frame_err strobes.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_p,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 sync_1;
    logic                 rx_s;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 bit_tick;
    logic                 half_tick;
    logic                 sample_bit;
    logic                 stop_good;
    logic                 stop_bad;

    // Synchronizer flops reset to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx_p;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (half_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (bit_tick) state_nxt = rx_s ? IDLE : BRK;
            BRK:     if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        bit_tick   = (cnt == CNT_LAST);
        half_tick  = (cnt == CNT_HALF);
        sample_bit = (state == DATA) && bit_tick;
        stop_good  = (state == STOP) && bit_tick && rx_s;
        stop_bad   = (state == STOP) && bit_tick && !rx_s;
    end

    // Counter restarts at start qualification so data samples land mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= stop_good;
            frame_err <= stop_bad;
            if (stop_good) data <= shreg;
            case (state)
                START: begin
                    cnt     <= half_tick ? '0 : cnt + 1'b1;
                    bit_idx <= 3'd0;
                end
                DATA, STOP: cnt <= bit_tick ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
            if (sample_bit) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: time-accurate line driver, expected-strobe queue
// with per-cycle compare, and directed literal checks on latency, glitch, break and reset.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    // Cycle (index of the preceding posedge) in which a strobe is visible, relative to e0;
    // a posedge sampler sees it at e0+2+HALF+9*CPB+1.
    localparam int LAT  = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_p      (rx_p),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    bit         exp_err_q[$];
    logic [7:0] model_data = 8'h00;
    logic       rst_q = 1'b1;
    int         cur_e0 = -1;
    logic       busy_log  [0:32767];
    logic       valid_log [0:32767];
    logic [7:0] data_log  [0:32767];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // Per-cycle compare against the expected-strobe queue and the last-good-byte model.
    always @(negedge clk) begin
        int k;
        k = int'($time) / 10 - 1;
        busy_log[k % 32768]  = busy;
        valid_log[k % 32768] = valid;
        data_log[k % 32768]  = data;
        if (rst_q) begin
            model_data = 8'h00;
            check("rst_valid", valid, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_busy", busy, 0);
        end else begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < k) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_strobe at t=%0t: got none, expected strobe at cycle %0d", $time, exp_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_err_q.pop_front());
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == k) begin
                if (exp_err_q[0]) begin
                    check("ferr_strobe", frame_err, 1);
                    check("ferr_no_valid", valid, 0);
                end else begin
                    check("valid_strobe", valid, 1);
                    check("valid_no_ferr", frame_err, 0);
                    model_data = exp_q[0];
                end
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_err_q.pop_front());
            end else begin
                check("no_valid", valid, 0);
                check("no_ferr", frame_err, 0);
            end
        end
        check("data", data, model_data);
    end

    // kind: 0 = expect valid, 1 = expect frame_err, 2 = expect nothing.
    task automatic send_frame(input logic [7:0] b, input logic stop, input real p,
                              input int kind, input int hold, input bit align, output int e0);
        real        t0;
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (align) @(negedge clk);
        rx_p = 1'b0;
        t0 = $realtime;
        @(posedge clk);
        e0 = int'($time) / 10;
        cur_e0 = e0;
        if (kind == 0 || kind == 1) begin
            exp_q.push_back(b);
            exp_cyc_q.push_back(e0 + LAT);
            exp_err_q.push_back(kind == 1);
        end
        for (int k = 1; k < 10; k++) begin
            #(t0 + k * p * 10.0 - $realtime);
            rx_p = bits[k];
        end
        #(t0 + 10.0 * p * 10.0 - $realtime);
        if (!stop) begin
            #(hold * 10.0);
            rx_p = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0;
        int cnt;
        int sel;
        real p;
        bit b2b;
        logic [7:0] b;

        rst = 1'b1;
        rx_p = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);

        // Nominal bytes
        send_frame(8'hA5, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(3);
        send_frame(8'h00, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(3);
        send_frame(8'hFF, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(3);

        // Exact latency of valid and busy
        send_frame(8'h3C, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(4);
        check("3c_busy_pre_start", busy_log[(e0 + 1) % 32768], 0);
        check("3c_busy_start", busy_log[(e0 + 2) % 32768], 1);
        check("3c_valid_early", valid_log[(e0 + LAT - 1) % 32768], 0);
        check("3c_busy_before", busy_log[(e0 + LAT - 1) % 32768], 1);
        check("3c_valid", valid_log[(e0 + LAT) % 32768], 1);
        check("3c_data", data_log[(e0 + LAT) % 32768], 8'h3C);
        check("3c_busy_fall", busy_log[(e0 + LAT) % 32768], 0);

        // Four-cycle low glitch on an idle line
        @(negedge clk);
        rx_p = 1'b0;
        e0 = int'($time) / 10;
        idle(4);
        rx_p = 1'b1;
        idle(30);
        cnt = 0;
        for (int i = 0; i <= 30; i++) cnt += int'(busy_log[(e0 + i) % 32768]);
        check("glitch_busy_cycles", cnt, HALF);
        check("glitch_busy_on", busy_log[(e0 + 2) % 32768], 1);
        check("glitch_busy_off", busy_log[(e0 + 2 + HALF) % 32768], 0);
        check("glitch_data_kept", data, 8'h3C);

        // Stop bit low, line held low 40 more cycles
        send_frame(8'h55, 1'b0, 16.0, 1, 40, 1'b1, e0);
        idle(5);
        cnt = 0;
        for (int i = LAT; i <= 201; i++) cnt += int'(busy_log[(e0 + i) % 32768]);
        check("brk_busy_held", cnt, 202 - LAT);
        check("brk_busy_release", busy_log[(e0 + 202) % 32768], 0);
        check("brk_data_kept", data, 8'h3C);
        send_frame(8'h81, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(3);
        check("after_brk_data", data, 8'h81);

        // Back-to-back, then +/-3% bit period
        send_frame(8'h12, 1'b1, 16.0, 0, 0, 1'b1, e0);
        send_frame(8'h34, 1'b1, 16.0, 0, 0, 1'b0, e0);
        idle(3);
        check("b2b_data", data, 8'h34);
        send_frame(8'h12, 1'b1, 15.52, 0, 0, 1'b1, e0);
        idle(3);
        send_frame(8'h34, 1'b1, 15.52, 0, 0, 1'b1, e0);
        idle(3);
        send_frame(8'h12, 1'b1, 16.48, 0, 0, 1'b1, e0);
        idle(3);
        send_frame(8'h34, 1'b1, 16.48, 0, 0, 1'b1, e0);
        idle(3);

        // Reset in the middle of data bit 4 of 0xF0
        cur_e0 = -1;
        fork
            send_frame(8'hF0, 1'b1, 16.0, 2, 0, 1'b1, e0);
            begin
                wait (cur_e0 >= 0);
                while (int'($time) / 10 - 1 < cur_e0 + 87) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(3);
        check("rst_mid_data", data_log[(e0 + 88) % 32768], 8'h00);
        check("rst_mid_busy", busy_log[(e0 + 88) % 32768], 0);
        send_frame(8'h0F, 1'b1, 16.0, 0, 0, 1'b1, e0);
        idle(3);
        check("after_rst_data", data, 8'h0F);

        // Random bytes, rates and gaps
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 2);
            p   = (sel == 0) ? 16.0 : ((sel == 1) ? 15.52 : 16.48);
            b2b = (sel == 0) && ($urandom_range(0, 1) == 1);
            send_frame(b, 1'b1, p, 0, 0, !b2b, e0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
        end

        idle(200);
        check("queue_drained", exp_cyc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
